// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus sequencer feeding a UART transmitter over a char/go/done handshake.
// Ports: CLK/RST (async, active-high); wr_data/wr_en enqueue; flush drops queued bytes;
// ovf_clr clears sticky overflow; full/empty/count/overflow/busy status;
// tx_char/tx_go drive the transmitter, tx_done is its completion level.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    input  logic                  flush,
    input  logic                  ovf_clr,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic [7:0]            tx_char,
    output logic                  tx_go,
    input  logic                  tx_done
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic [1:0] {IDLE, GO, SETTLE, WAIT} state_t;
    state_t                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d, tx_go_q, tx_go_d;
    logic [7:0]            tx_char_q, tx_char_d;
    logic                  wr_ok, pop;
    assign full     = count_q == (DEPTH_LOG2+1)'(DEPTH);
    assign empty    = count_q == '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = state_q != IDLE;
    assign tx_char  = tx_char_q;
    assign tx_go    = tx_go_q;
    always_comb begin
        wr_ok      = wr_en && !full && !flush;
        // flush cancels a same-cycle pop; the sequencer simply stays in IDLE
        pop        = state_q == IDLE && !empty && !flush;
        wr_ptr_d   = flush ? '0 : wr_ptr_q + DEPTH_LOG2'(wr_ok);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + DEPTH_LOG2'(pop);
        count_d    = flush ? '0 : count_q + (DEPTH_LOG2+1)'(wr_ok) - (DEPTH_LOG2+1)'(pop);
        // a dropped write is judged on the pre-edge full, and set beats clear
        overflow_d = (wr_en && full) || (overflow_q && !ovf_clr);
        tx_char_d  = pop ? mem_q[rd_ptr_q] : tx_char_q;
        tx_go_d    = pop;
        // SETTLE deliberately ignores tx_done: it may still be high from the last frame
        case (state_q)
            IDLE:    state_d = pop ? GO : IDLE;
            GO:      state_d = SETTLE;
            SETTLE:  state_d = WAIT;
            WAIT:    state_d = tx_done ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_char_q  <= 8'h00;
            tx_go_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_char_q  <= tx_char_d;
            tx_go_q    <= tx_go_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed and random stimulus against a queue-based reference of the feeder.
module tb_uart_tx_feeder;
    logic       CLK, RST;
    logic [7:0] wr_data;
    logic       wr_en, flush, ovf_clr, tx_done;
    logic       full, empty, overflow, busy, tx_go;
    logic [4:0] count;
    logic [7:0] tx_char;
    logic [7:0] m_q [$];
    bit         m_idle, m_ovf, f_act;
    int         m_age, f_age, frame_len;
    logic [7:0] last_char;
    int         checks, errors;
    uart_tx_feeder #(.DEPTH_LOG2(4)) dut (
        .CLK(CLK), .RST(RST), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
        .ovf_clr(ovf_clr), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .busy(busy), .tx_char(tx_char), .tx_go(tx_go),
        .tx_done(tx_done)
    );
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_clear();
        m_q.delete();
        m_idle = 1'b1;
        m_age = 0;
        m_ovf = 1'b0;
        last_char = 8'h00;
        f_act = 1'b0;
        f_age = 0;
        tx_done = 1'b0;
    endtask
    task automatic do_reset();
        RST = 1'b1;
        wr_en = 1'b0;
        flush = 1'b0;
        ovf_clr = 1'b0;
        wr_data = 8'h00;
        model_clear();
        @(posedge CLK);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_go", 32'(tx_go), 32'd0);
        chk("rst_char", 32'(tx_char), 32'd0);
        RST = 1'b0;
    endtask
    // One clock: model predicts the edge from pre-edge values, transmitter model reacts after it.
    task automatic cycle(input logic we, input logic [7:0] wd, input logic fl, input logic oc);
        bit pre_full, pop, wacc;
        wr_en = we;
        wr_data = wd;
        flush = fl;
        ovf_clr = oc;
        pre_full = m_q.size() == 16;
        pop = m_idle && m_q.size() != 0 && !fl;
        wacc = we && !pre_full && !fl;
        if (pop) begin
            last_char = m_q.pop_front();
            m_idle = 1'b0;
            m_age = 0;
        end else if (!m_idle) begin
            if (m_age >= 2 && tx_done) m_idle = 1'b1;
            else m_age++;
        end
        if (fl) m_q.delete();
        else if (wacc) m_q.push_back(wd);
        m_ovf = (we && pre_full) || (m_ovf && !oc);
        @(posedge CLK);
        #1;
        wr_en = 1'b0;
        flush = 1'b0;
        ovf_clr = 1'b0;
        // transmitter: done stays stale-high through GO and SETTLE, then drops for the frame
        if (tx_go) begin
            f_act = 1'b1;
            f_age = 0;
        end else if (f_act) begin
            f_age++;
            if (f_age == 2) tx_done = 1'b0;
            if (f_age >= 2 + frame_len) begin
                tx_done = 1'b1;
                f_act = 1'b0;
            end
        end
        chk("tx_go", 32'(tx_go), 32'(pop));
        chk("tx_char", 32'(tx_char), 32'(last_char));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("full", 32'(full), 32'(m_q.size() == 16));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'(!m_idle));
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask
    task automatic drain(input int limit);
        for (int i = 0; i < limit && !(m_idle && m_q.size() == 0); i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
    endtask
    initial begin
        checks = 0;
        errors = 0;
        frame_len = 40;
        do_reset();
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        idle(1);
        chk("single_char", 32'(tx_char), 32'h55);
        drain(80);
        chk("single_held", 32'(tx_char), 32'h55);
        frame_len = 60;
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        idle(3);
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("burst_full", 32'(full), 32'd1);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_set", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        frame_len = 4;
        drain(400);
        frame_len = 6;
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        idle(2);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !(m_idle && m_q.size() == 1); i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pop_ready_count", 32'(count), 32'd1);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        chk("wr_pop_count", 32'(count), 32'd1);
        chk("wr_pop_go", 32'(tx_go), 32'd1);
        drain(100);
        chk("wr_pop_last", 32'(tx_char), 32'h33);
        frame_len = 30;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        idle(4);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_busy", 32'(busy), 32'd1);
        idle(50);
        chk("flush_last", 32'(tx_char), 32'hA0);
        drain(60);
        frame_len = 10;
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 8'h78, 1'b0, 1'b0);
        chk("arst_go_seen", 32'(tx_go), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_go", 32'(tx_go), 32'd0);
        chk("arst_char", 32'(tx_char), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        do_reset();
        idle(3);
        for (int i = 0; i < 700; i++) begin
            if (!f_act) frame_len = int'($urandom_range(1, 12));
            cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 199) == 0,
                  $urandom_range(0, 49) == 0);
        end
        frame_len = 3;
        drain(600);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte FIFO and sequencer that sits directly upstream of the UART transmitter. Producers write bytes at any rate up to one per clock. The block hands them to the transmitter one at a time over its char/go/done_sig handshake, holding each character stable until the transmitter reports completion. It provides the CPU-side buffering and flow-control status for the serial console.

## Interface
- DEPTH_LOG2, default 4: FIFO holds 2^DEPTH_LOG2 bytes (16).
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue strobe, one byte per cycle.
- flush  in  1  discard all queued bytes; does not affect the in-flight byte.
- ovf_clr  in  1  clears the overflow flag.
- full  out  1  count == 2^DEPTH_LOG2.
- empty  out  1  count == 0.
- count  out  DEPTH_LOG2+1  number of queued bytes; excludes the in-flight byte.
- overflow  out  1  sticky; set when a write is dropped.
- busy  out  1  sequencer not in IDLE.
- tx_char  out  8  character to the transmitter; registered; held from pop until the next pop.
- tx_go  out  1  registered one-cycle start pulse to the transmitter.
- tx_done  in  1  transmitter done level. Low from reset and for one cycle after go is accepted. High once the frame completes, and stays high until the next go.

## Operation
- Storage: 2^DEPTH_LOG2 × 8 register array, read pointer rd_ptr and write pointer wr_ptr, each DEPTH_LOG2 bits, wrapping modulo depth. count is a separate register.
- Write: when wr_en && !full && !flush, store mem[wr_ptr] <= wr_data and wr_ptr++.
- Dropped write: wr_en while full drops the byte and sets overflow. This holds even if a pop occurs the same cycle, because full is the pre-edge registered value.
- count: next = count + write_accepted − pop. A simultaneous write and pop leaves count unchanged.
- flush: rd_ptr = wr_ptr = count = 0 at the edge. A same-cycle write and pop are both cancelled; the sequencer still advances its own state. flush does not touch overflow.
- overflow: cleared by RST or ovf_clr. If set and clear coincide, set wins.
- Sequencer states:
  - IDLE: if !empty, pop at the edge: tx_char <= mem[rd_ptr], rd_ptr++, tx_go <= 1, go to GO.
  - GO: tx_go is high for this cycle. At the edge, tx_go <= 0 and go to SETTLE.
  - SETTLE: one cycle, covering the transmitter's done-clear latency. Ignore tx_done. Go to WAIT.
  - WAIT: stay until tx_done == 1, then go to IDLE.
  - Unused encodings go to IDLE.
- tx_char is not changed between pops. The transmitter samples it after go, so it must remain stable.
- busy = (state != IDLE).

## Timing
- Reset values: tx_char = 0x00, tx_go = 0, full = 0, empty = 1, count = 0, overflow = 0, busy = 0, state = IDLE, pointers = 0. Memory contents are don't-care.
- RST mid-frame: the feeder returns to IDLE immediately. The in-flight byte is not re-sent. The transmitter is reset by the same system reset.
- Write-to-go latency: a write accepted at edge 0 gives empty = 0 after edge 0. tx_char and tx_go = 1 are valid after edge 1, and tx_go = 0 after edge 2.
- Back-to-back throughput: tx_done rising at edge n gives IDLE after edge n. The next pop and tx_go = 1 come after edge n+1. Minimum gap is 2 cycles plus the transmitter frame time.
- Pointer wrap: after 2^DEPTH_LOG2 writes, wr_ptr returns to 0. full/empty come from count, never from pointer equality.
- A pop on the last byte makes empty = 1 at the same edge that raises tx_go.
- tx_done is ignored in IDLE, GO and SETTLE. A stale high tx_done from the previous frame must never cause a skip.

## Test plan
- Single byte: write 0x55 at cycle 0 → tx_char = 0x55 and tx_go = 1 for exactly cycle 2; busy = 1. The model raises tx_done 40 cycles later → IDLE, busy = 0, empty = 1.
- Burst: write 0x01..0x10 (16 bytes) on consecutive cycles → full = 1 after the 16th write. The transmitter model receives 0x01..0x10 in order, one tx_go per done, with tx_char stable between gos.
- Overflow: with the FIFO full and the sequencer in WAIT, write 0xAA → byte dropped, count = 16, overflow = 1. Pulse ovf_clr → overflow = 0.
- Simultaneous write and pop: count = 1 in IDLE, write 0x33 on the pop edge → count stays 1; 0x33 is the next byte sent.
- Flush mid-transfer: queue 5 bytes, flush during WAIT → count = 0, empty = 1. The in-flight byte completes and no further tx_go occurs.
- Async reset: assert RST during GO, between clock edges → tx_go = 0, tx_char = 0x00 and empty = 1 immediately, without waiting for a clock edge.
